// File: rtl/sim_exit_ctrl_if.sv
// ============================================================================
// sim_exit_ctrl_if : OBI-style single-outstanding bus between firmware master
//                    and the simulation-control responder.    Rev 1.0
// ============================================================================
`default_nettype none

interface sim_exit_ctrl_if #(
  parameter int ADDR_W = 8
) ();
  logic              req_i;
  logic              we_i;
  logic [3:0]        be_i;
  logic [ADDR_W-1:0] addr_i;
  logic [31:0]       wdata_i;
  logic              gnt_o;
  logic              rvalid_o;
  logic [31:0]       rdata_o;

  modport master (
    output req_i, we_i, be_i, addr_i, wdata_i,
    input  gnt_o, rvalid_o, rdata_o
  );

  modport slave (
    input  req_i, we_i, be_i, addr_i, wdata_i,
    output gnt_o, rvalid_o, rdata_o
  );
endinterface

`default_nettype wire

// File: rtl/sim_exit_ctrl.sv
// ============================================================================
// sim_exit_ctrl : exit-code / dump-trigger / cycle-counter responder for the
//                 testharness. Optional watchdog: SIM_EXIT_WATCHDOG_EN. Rev 1.0
// ============================================================================
`default_nettype none

module sim_exit_ctrl #(
  parameter int ADDR_W     = 8,
  parameter int EXIT_DELAY = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  sim_exit_ctrl_if.slave       bus,
  output logic                 exit_valid_o,
  output logic [31:0]          exit_value_o,
  output logic                 dump_trig_o
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int OFF_W = ADDR_W - 2;
  localparam logic [OFF_W-1:0] OFF_EXIT_VALUE = OFF_W'(0);
  localparam logic [OFF_W-1:0] OFF_EXIT_CTRL  = OFF_W'(1);
  localparam logic [OFF_W-1:0] OFF_DUMP_CTRL  = OFF_W'(2);
  localparam logic [OFF_W-1:0] OFF_CYCLE      = OFF_W'(3);

  // The accept cycle itself counts as the first drain cycle, so the counter
  // holds EXIT_DELAY-1 on entry and exit_valid_o rises EXIT_DELAY cycles later.
  localparam int CNT_W = (EXIT_DELAY > 1) ? $clog2(EXIT_DELAY) : 1;
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(EXIT_DELAY - 1);

`ifdef SIM_EXIT_WATCHDOG_EN
  localparam logic [OFF_W-1:0] OFF_WDOG  = OFF_W'(4);
  localparam logic [31:0]      WDOG_CODE = 32'hDEAD_0001;
`endif

  state_e            state_q,      state_d;
  logic [CNT_W-1:0]  drain_cnt_q,  drain_cnt_d;
  logic [31:0]       exit_value_q, exit_value_d;
  logic [31:0]       exit_code_q,  exit_code_d;
  logic              dump_q,       dump_d;
  logic [31:0]       cycle_q,      cycle_d;
  logic              rvalid_q,     rvalid_d;
  logic [31:0]       rdata_q,      rdata_d;
`ifdef SIM_EXIT_WATCHDOG_EN
  logic [31:0]       wdog_q,       wdog_d;
  logic              w_wdog_hit;
`endif

  logic [OFF_W-1:0]  w_off;
  logic              w_wr;
  logic              w_rd;
  logic              w_start;
  logic [1:0]        unused_addr_lsb;

  assign w_off           = bus.addr_i[ADDR_W-1:2];
  assign unused_addr_lsb = bus.addr_i[1:0];
  assign w_wr            = bus.req_i &  bus.we_i;
  assign w_rd            = bus.req_i & ~bus.we_i;
  assign w_start         = w_wr && (w_off == OFF_EXIT_CTRL) && bus.be_i[0] && bus.wdata_i[0];

`ifdef SIM_EXIT_WATCHDOG_EN
  assign w_wdog_hit = (wdog_q != 32'd0) && (cycle_q == wdog_q);
`endif

  // Register file updates
  always_comb begin
    exit_value_d = exit_value_q;
    dump_d       = dump_q;
    cycle_d      = cycle_q + 32'd1;
`ifdef SIM_EXIT_WATCHDOG_EN
    wdog_d       = wdog_q;
`endif
    if (w_wr && (w_off == OFF_EXIT_VALUE) && (state_q == ST_RUN)) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.be_i[b]) exit_value_d[8*b +: 8] = bus.wdata_i[8*b +: 8];
      end
    end
    if (w_wr && (w_off == OFF_DUMP_CTRL) && bus.be_i[0]) begin
      dump_d = bus.wdata_i[0];
    end
`ifdef SIM_EXIT_WATCHDOG_EN
    if (w_wr && (w_off == OFF_WDOG)) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.be_i[b]) wdog_d[8*b +: 8] = bus.wdata_i[8*b +: 8];
      end
    end
`endif
  end

  // Response path: data is captured at accept and presented for one cycle
  always_comb begin
    rvalid_d = bus.req_i;
    rdata_d  = 32'd0;
    if (w_rd) begin
      case (w_off)
        OFF_EXIT_VALUE: rdata_d = exit_value_q;
        OFF_EXIT_CTRL:  rdata_d = {30'd0, state_q == ST_DONE, state_q == ST_DRAIN};
        OFF_DUMP_CTRL:  rdata_d = {31'd0, dump_q};
        OFF_CYCLE:      rdata_d = cycle_q;
`ifdef SIM_EXIT_WATCHDOG_EN
        OFF_WDOG:       rdata_d = wdog_q;
`endif
        default:        rdata_d = 32'd0;
      endcase
    end
  end

  // Exit FSM
  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    exit_code_d = exit_code_q;
    case (state_q)
      ST_RUN: begin
        if (w_start) begin
          exit_code_d = exit_value_q;
          if (EXIT_DELAY <= 1) begin
            state_d = ST_DONE;
          end else begin
            state_d     = ST_DRAIN;
            drain_cnt_d = DRAIN_LOAD;
          end
        end
`ifdef SIM_EXIT_WATCHDOG_EN
        else if (w_wdog_hit) begin
          state_d     = ST_DONE;
          exit_code_d = WDOG_CODE;
        end
`endif
      end
      ST_DRAIN: begin
        drain_cnt_d = drain_cnt_q - 1'b1;
        if (drain_cnt_q == CNT_W'(1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_RUN;
      drain_cnt_q  <= '0;
      exit_value_q <= '0;
      exit_code_q  <= '0;
      dump_q       <= 1'b0;
      cycle_q      <= '0;
      rvalid_q     <= 1'b0;
      rdata_q      <= '0;
`ifdef SIM_EXIT_WATCHDOG_EN
      wdog_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      drain_cnt_q  <= drain_cnt_d;
      exit_value_q <= exit_value_d;
      exit_code_q  <= exit_code_d;
      dump_q       <= dump_d;
      cycle_q      <= cycle_d;
      rvalid_q     <= rvalid_d;
      rdata_q      <= rdata_d;
`ifdef SIM_EXIT_WATCHDOG_EN
      wdog_q       <= wdog_d;
`endif
    end
  end

  assign bus.gnt_o    = bus.req_i;
  assign bus.rvalid_o = rvalid_q;
  assign bus.rdata_o  = rdata_q;

  assign exit_valid_o = (state_q == ST_DONE);
  assign exit_value_o = exit_valid_o ? exit_code_q : 32'd0;
  assign dump_trig_o  = dump_q;

endmodule

`default_nettype wire
